// File: rtl/freq_meas_seq.sv
// Equal-precision frequency measurement sequencer: gates on signal edges, counts
// signal periods (nx) and reference cycles (ns), delivers them over valid/ready.
module freq_meas_seq #(
   parameter int GATE_W  = 32,
   parameter int CNT_W   = 32,
   parameter int TMO_CYC = 400_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sig_in,
   input  logic              start,
   input  logic              cont,
   input  logic [GATE_W-1:0] gate_len,
   output logic              busy,
   output logic              gate_open,
   output logic [CNT_W-1:0]  nx,
   output logic [CNT_W-1:0]  ns,
   output logic              res_tmo,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam int CMP_W = (CNT_W > GATE_W) ? CNT_W : GATE_W;
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {IDLE, WAIT_OPEN, GATE, DONE} state_t;

   state_t            state;
   logic [2:0]        sync_q;
   logic [GATE_W-1:0] gate_lat;
   logic [CNT_W-1:0]  nx_cnt;
   logic [CNT_W-1:0]  ns_cnt;
   logic [TMO_W-1:0]  idle_cnt;

   logic              rise;
   logic [CNT_W-1:0]  nx_inc;
   logic [CNT_W-1:0]  ns_inc;
   logic              win_done;
   logic              tmo_hit;

   // Two synchronizer flops, third flop is the edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], sig_in};
   end

   assign rise     = sync_q[1] & ~sync_q[2];
   assign nx_inc   = (&nx_cnt) ? nx_cnt : nx_cnt + 1'b1;
   assign ns_inc   = (&ns_cnt) ? ns_cnt : ns_cnt + 1'b1;
   assign win_done = CMP_W'(ns_inc) >= CMP_W'(gate_lat);
   assign tmo_hit  = (idle_cnt == TMO_W'(TMO_CYC));

   // NOTE: every register here is assigned with <= so all of them update from
   // the same pre-edge values; mixing in = would make results order-dependent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gate_lat  <= '0;
         nx_cnt    <= '0;
         ns_cnt    <= '0;
         idle_cnt  <= '0;
         busy      <= 1'b0;
         gate_open <= 1'b0;
         nx        <= '0;
         ns        <= '0;
         res_tmo   <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if ((start || cont) && !res_valid) begin
                  gate_lat <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                  nx_cnt   <= '0;
                  ns_cnt   <= '0;
                  idle_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= WAIT_OPEN;
               end
            end

            WAIT_OPEN: begin
               if (rise) begin
                  gate_open <= 1'b1;
                  nx_cnt    <= '0;
                  ns_cnt    <= '0;
                  idle_cnt  <= '0;
                  state     <= GATE;
               end else if (tmo_hit) begin
                  nx        <= '0;
                  ns        <= '0;
                  res_tmo   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            GATE: begin
               ns_cnt <= ns_inc;
               if (rise) begin
                  nx_cnt   <= nx_inc;
                  idle_cnt <= '0;
                  // The closing edge belongs to the window: counted in both nx and ns.
                  if (win_done) begin
                     gate_open <= 1'b0;
                     nx        <= nx_inc;
                     ns        <= ns_inc;
                     res_tmo   <= 1'b0;
                     res_valid <= 1'b1;
                     state     <= DONE;
                  end
               end else if (tmo_hit) begin
                  gate_open <= 1'b0;
                  nx        <= '0;
                  ns        <= '0;
                  res_tmo   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            DONE: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meas_seq.sv
// Self-checking bench for freq_meas_seq: an arithmetic model of the expected
// result (nx = ceil(gate/P), ns = nx*P, or a zero timeout result) plus directed runs.
module tb_freq_meas_seq;

   localparam int TMO = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sig_in;
   logic        start;
   logic        cont;
   logic        res_ready;
   logic [31:0] gate_len;
   logic        busy;
   logic        gate_open;
   logic [31:0] nx;
   logic [31:0] ns;
   logic        res_tmo;
   logic        res_valid;

   int   checks   = 0;
   int   failures = 0;
   int   sig_per  = 0;
   int   exp_nx   = 0;
   int   exp_ns   = 0;
   logic exp_tmo  = 1'b0;
   int   gate_cyc = 0;
   int   xfers    = 0;

   freq_meas_seq #(.GATE_W(32), .CNT_W(32), .TMO_CYC(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sig_in    (sig_in),
      .start     (start),
      .cont      (cont),
      .gate_len  (gate_len),
      .busy      (busy),
      .gate_open (gate_open),
      .nx        (nx),
      .ns        (ns),
      .res_tmo   (res_tmo),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   // Signal of exactly sig_per clk cycles, edges offset from clk; 0 stops it low.
   initial begin
      sig_in = 1'b0;
      forever begin
         @(posedge clk);
         if (sig_per != 0) begin
            #3 sig_in = 1'b1;
            repeat (sig_per / 2) @(posedge clk);
            #3 sig_in = 1'b0;
            repeat (sig_per - sig_per / 2 - 1) @(posedge clk);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) if (gate_open) gate_cyc++;
   always @(negedge clk) if (res_valid && res_ready) xfers++;

   // Result must match the model on every cycle it is presented.
   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         check("cmp_nx", nx, exp_nx);
         check("cmp_ns", ns, exp_ns);
         check("cmp_tmo", res_tmo, exp_tmo);
      end
   end

   task automatic wait_valid(input int max_cyc, output int cyc);
      cyc = 0;
      while (!res_valid && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
      end
      check("res_valid_within_budget", res_valid, 1);
   endtask

   task automatic wait_gate(input int max_cyc);
      int c = 0;
      while (!gate_open && c < max_cyc) begin
         @(negedge clk);
         c++;
      end
      check("gate_opened_within_budget", gate_open, 1);
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("ack_clears_valid", res_valid, 0);
      check("ack_clears_busy", busy, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_gate_open"}, gate_open, 0);
      check({tag, "_nx"}, nx, 0);
      check({tag, "_ns"}, ns, 0);
      check({tag, "_res_tmo"}, res_tmo, 0);
      check({tag, "_res_valid"}, res_valid, 0);
   endtask

   task automatic run_one(input int per, input int glen, input int lit_nx, input int lit_ns);
      int g;
      int cyc;
      int g0;
      g       = (glen == 0) ? 1 : glen;
      exp_nx  = (g + per - 1) / per;
      exp_ns  = exp_nx * per;
      exp_tmo = 1'b0;
      sig_per  = per;
      gate_len = glen;
      repeat (30) @(negedge clk);
      g0 = gate_cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_one_cycle_after_start", busy, 1);
      wait_valid(3000, cyc);
      check("gate_open_cycles", gate_cyc - g0, exp_ns);
      check("nx_literal", nx, lit_nx);
      check("ns_literal", ns, lit_ns);
      check("tmo_clear", res_tmo, 0);
   endtask

   initial begin
      int cyc;
      int r0;
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; res_ready = 1'b0; gate_len = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Period 10, window 100; result held while res_ready is low, start ignored.
      run_one(10, 100, 10, 100);
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (299) @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_nx", nx, 10);
      check("hold_ns", ns, 100);
      ack();
      repeat (5) @(negedge clk);
      check("no_rearm_after_ignored_start", busy, 0);

      // Period 7: window 100 and window 0 (treated as 1).
      run_one(7, 100, 15, 105);
      ack();
      run_one(7, 0, 1, 7);
      ack();

      // Constant-low signal: timeout about TMO cycles after arm.
      sig_per = 0; exp_nx = 0; exp_ns = 0; exp_tmo = 1'b1; gate_len = 100;
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(3000, cyc);
      check("tmo_latency_in_window", (cyc >= TMO && cyc <= TMO + 2), 1);
      check("tmo_flag", res_tmo, 1);
      check("tmo_nx_zero", nx, 0);
      check("tmo_gate_closed", gate_open, 0);
      ack();

      // Signal stops mid-gate: same timeout result.
      sig_per = 10; gate_len = 100;
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_gate(200);
      repeat (30) @(negedge clk);
      sig_per = 0;
      wait_valid(3000, cyc);
      check("midgate_tmo_flag", res_tmo, 1);
      check("midgate_ns_zero", ns, 0);
      check("midgate_gate_closed", gate_open, 0);
      ack();

      // Continuous mode with res_ready high, then drop cont mid-gate.
      exp_nx = 5; exp_ns = 50; exp_tmo = 1'b0;
      sig_per = 10; gate_len = 50; res_ready = 1'b1;
      repeat (30) @(negedge clk);
      r0 = xfers;
      cont = 1'b1;
      cyc = 0;
      while (xfers < r0 + 3 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("cont_back_to_back_results", (xfers - r0 >= 3), 1);
      wait_gate(200);
      cont = 1'b0;
      r0 = xfers;
      cyc = 0;
      while (busy && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("cont_drop_busy_low", busy, 0);
      check("cont_drop_last_delivered", xfers - r0, 1);
      repeat (30) @(negedge clk);
      check("cont_drop_no_rearm", busy, 0);
      check("cont_drop_no_extra_result", xfers - r0, 1);
      res_ready = 1'b0;

      // Reset during GATE clears everything at once; a fresh run follows.
      exp_nx = 10; exp_ns = 100; exp_tmo = 1'b0; gate_len = 100;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_gate(200);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero_outputs("midgate_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_one(10, 100, 10, 100);
      ack();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
